mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Bus-master block that drives the single-port data memory's address/write interface to copy a block of words from a source region to a destination region, or to fill a region with a constant. It sits between a control source (testbench, loader or a future CPU-side control register) and the memory's `address`/`write_data`/`mem_write`/`read_data` port. It takes over the port while busy. Memory reads are combinational and writes commit on the next `posedge clk`.

## Interface
Parameters:
- `ADDR_W`, 32: memory address width (word addresses).
- `DATA_W`, 32: data word width.
- `LEN_W`, 16: width of the transfer length.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `mode`  in  1  0 = COPY, 1 = FILL; captured with `start`.
- `src_addr`  in  ADDR_W  first source word address (COPY only).
- `dst_addr`  in  ADDR_W  first destination word address.
- `length`  in  LEN_W  number of words to transfer.
- `fill_value`  in  DATA_W  word written in FILL mode.
- `busy`  out  1  high in READ and WRITE states.
- `done`  out  1  single-cycle completion pulse.
- `words_done`  out  LEN_W  words written so far in the current or last transfer.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_write_data`  out  DATA_W  to memory `write_data`.
- `mem_write`  out  1  to memory `mem_write`.
- `mem_read_data`  in  DATA_W  from memory `read_data`; valid in the same cycle as the address.

## Operation
- The FSM has four states: IDLE, READ, WRITE and DONE.
- **IDLE**
  - Outputs: `mem_address`=0, `mem_write`=0, `mem_write_data`=0.
  - When `start`=1, the block captures `mode`, `src_addr`, `dst_addr`, `length` and `fill_value`, and clears `words_done`.
  - Next state: `length`=0 → DONE; FILL → WRITE; COPY → READ.
- **READ** (COPY only)
  - `mem_address`=src pointer.
  - At the clock edge, `mem_read_data` is latched into the data register and the block goes to WRITE.
- **WRITE**
  - Outputs: `mem_address`=dst pointer, `mem_write`=1.
  - `mem_write_data` is the latched word in COPY mode and `fill_value` in FILL mode.
  - At the clock edge: both pointers +1, `words_done` +1, remaining count −1.
  - If the remaining count reaches 0 → DONE; otherwise → READ (COPY) or stay in WRITE (FILL).
- **DONE**
  - Outputs: `done`=1, `busy`=0, `mem_write`=0.
  - Unconditional transition to IDLE.
  - `start` is ignored in this state.
- Pointer arithmetic is modulo 2^ADDR_W and wraps silently. Range checking against the memory size is the caller's responsibility.
- Copies run forward only. With overlapping regions where dst > src, already-written words are re-read; this is the defined behaviour.
- `start` while busy or in DONE is ignored and does not queue.
- `words_done` holds its final value until the next accepted `start`.

## Timing
- Let the accepting edge be e0.
- **COPY, N words**
  - The read of word k is in the cycle after edge e(2k).
  - The write of word k commits at edge e(2k+2).
  - `done` is high in the cycle after e(2N).
  - Throughput: 2 cycles per word.
- **FILL, N words**
  - Word k commits at edge e(k+1).
  - `done` is high in the cycle after eN.
  - Throughput: 1 cycle per word.
- **length=0**: `done` is high in the cycle after e0, with no memory writes.
- **Reset values**: state IDLE, `busy`=0, `done`=0, `words_done`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0.
- **Reset mid-transfer**
  - The block is in IDLE at the next edge, with no further writes and no `done` pulse.
  - A write already committed at that edge stands. Note that this block's reset does not itself clear memory.
- All outputs are registered-state decodes with no combinational path from `start` to `mem_write`.

## Structure
- Shared package `mem_copy_pkg` holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - the mode constants `MODE_COPY`=0 and `MODE_FILL`=1.
- No sub-module is needed. Everything lives in one module: the FSM, two pointer registers, the remaining-count register, the data latch and the `words_done` counter.

## Test plan
- **COPY 4 words**: preload mem[10..13]=A0,A1,A2,A3, start COPY src=10 dst=40 len=4 → mem[40..43]=A0..A3; `done` one cycle after e8; `words_done`=4; mem[10..13] unchanged.
- **FILL 5 words**: start FILL dst=100 len=5 fill=DEADBEEF → mem[100..104]=DEADBEEF; `mem_write` high for exactly 5 cycles; `done` after e5; mem[99] and mem[105] untouched.
- **Zero length**: start len=0 → `done` in the cycle after e0; `mem_write` never asserted; `busy` never high.
- **Overlap**: mem[0..3]=1,2,3,4, COPY src=0 dst=1 len=3 → mem[0..3]=1,1,1,1.
- **Reset mid-copy**: COPY len=8 with reset asserted after e5 → 2 words written, IDLE next cycle, no `done`; a new start then completes normally.
- **Start while busy**: pulse `start` with different operands during WRITE → ignored; the original transfer completes unchanged and only one `done` pulse occurs.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy/fill engine: FSM state encoding and mode constants.
package mem_copy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus master that copies a block of words between memory regions, or fills a region
// with a constant, through the single-port data memory interface.
module mem_copy_engine #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  words_done,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data
);
   import mem_copy_pkg::*;

   state_t            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [LEN_W-1:0]  words_done_q, words_done_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] fill_q, fill_d;

   // Next-state and datapath update for the transfer sequencer.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      src_d        = src_q;
      dst_d        = dst_q;
      rem_d        = rem_q;
      words_done_d = words_done_q;
      data_d       = data_q;
      fill_d       = fill_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d       = mode;
               src_d        = src_addr;
               dst_d        = dst_addr;
               rem_d        = length;
               fill_d       = fill_value;
               words_done_d = '0;
               if (length == '0) begin
                  state_d = ST_DONE;
               end else if (mode == MODE_FILL) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            data_d  = mem_read_data;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            src_d        = src_q + ADDR_W'(1);
            dst_d        = dst_q + ADDR_W'(1);
            rem_d        = rem_q - LEN_W'(1);
            words_done_d = words_done_q + LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
               state_d = ST_DONE;
            end else if (mode_q == MODE_FILL) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_COPY;
         src_q        <= '0;
         dst_q        <= '0;
         rem_q        <= '0;
         words_done_q <= '0;
         data_q       <= '0;
         fill_q       <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         rem_q        <= rem_d;
         words_done_q <= words_done_d;
         data_q       <= data_d;
         fill_q       <= fill_d;
      end
   end

   // Memory port decode; reset withholds the strobe so an aborted transfer commits nothing more.
   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      case (state_q)
         ST_READ: begin
            busy        = 1'b1;
            mem_address = src_q;
         end
         ST_WRITE: begin
            busy           = 1'b1;
            mem_write      = ~reset;
            mem_address    = dst_q;
            mem_write_data = (mode_q == MODE_FILL) ? fill_q : data_q;
         end
         ST_DONE: done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: a transaction-level model predicts the per-cycle bus activity
// and the final memory image; a few literal expectations pin the model.
module tb_mem_copy_engine;
   import mem_copy_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] src_addr = 32'd0;
   logic [31:0] dst_addr = 32'd0;
   logic [15:0] length = 16'd0;
   logic [31:0] fill_value = 32'd0;
   logic        busy, done, mem_write;
   logic [15:0] words_done;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
      .busy(busy), .done(done), .words_done(words_done),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory behind the port plus a bench-side preload path
   logic [31:0] tb_mem [256];
   logic [31:0] model_mem [256];
   logic        pl_we = 1'b0;
   logic [7:0]  pl_addr = 8'd0;
   logic [31:0] pl_data = 32'd0;
   int          wr_cnt = 0, done_cnt = 0, busy_cnt = 0;

   assign mem_read_data = tb_mem[mem_address[7:0]];

   always @(posedge clk) begin
      if (mem_write) tb_mem[mem_address[7:0]] <= mem_write_data;
      if (pl_we) tb_mem[pl_addr] <= pl_data;
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        wr;
      logic        chk_addr;
      logic        chk_data;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] wd;
   } exp_t;

   exp_t        exp_q [$];
   int          checks = 0, failures = 0, cyc = 0;
   bit          cmp_en = 1'b0;
   logic [15:0] model_wd = 16'd0;

   // Per-cycle comparison against the predicted schedule (idle when nothing is pending)
   always @(negedge clk) begin
      exp_t e;
      logic bad;
      cyc++;
      if (cmp_en) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{busy:1'b0, done:1'b0, wr:1'b0, chk_addr:1'b1, chk_data:1'b1,
                    addr:32'd0, data:32'd0, wd:model_wd};
         bad = (busy !== e.busy) || (done !== e.done) || (mem_write !== e.wr) ||
               (words_done !== e.wd);
         if (e.chk_addr && (mem_address !== e.addr)) bad = 1'b1;
         if (e.chk_data && (mem_write_data !== e.data)) bad = 1'b1;
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL cycle%0d bus: got busy=%b done=%b wr=%b addr=%h data=%h wd=%0d, expected busy=%b done=%b wr=%b addr=%h data=%h wd=%0d",
                     cyc, busy, done, mem_write, mem_address, mem_write_data, words_done,
                     e.busy, e.done, e.wr, e.addr, e.data, e.wd);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic mem_init(input int a, input logic [31:0] d);
      pl_addr = 8'(a);
      pl_data = d;
      pl_we = 1'b1;
      model_mem[a % 256] = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   // Predict the whole transfer, launch it, optionally inject a stray start, wait for drain
   task automatic run_xfer(input logic md, input int src, input int dst, input int len,
                           input logic [31:0] fv, input int interrupt_at);
      exp_t        e;
      logic [31:0] v;
      int          budget;
      @(posedge clk); #1;
      mode = md; src_addr = 32'(src); dst_addr = 32'(dst); length = 16'(len);
      fill_value = fv; start = 1'b1;
      exp_q.push_back('{busy:1'b0, done:1'b0, wr:1'b0, chk_addr:1'b1, chk_data:1'b1,
                        addr:32'd0, data:32'd0, wd:model_wd});
      for (int k = 0; k < len; k++) begin
         if (md == MODE_COPY) begin
            exp_q.push_back('{busy:1'b1, done:1'b0, wr:1'b0, chk_addr:1'b1, chk_data:1'b0,
                              addr:32'(src + k), data:32'd0, wd:16'(k)});
            v = model_mem[(src + k) % 256];
         end else begin
            v = fv;
         end
         model_mem[(dst + k) % 256] = v;
         exp_q.push_back('{busy:1'b1, done:1'b0, wr:1'b1, chk_addr:1'b1, chk_data:1'b1,
                           addr:32'(dst + k), data:v, wd:16'(k)});
      end
      exp_q.push_back('{busy:1'b0, done:1'b1, wr:1'b0, chk_addr:1'b0, chk_data:1'b0,
                        addr:32'd0, data:32'd0, wd:16'(len)});
      model_wd = 16'(len);
      @(posedge clk); #1;
      start = 1'b0;
      if (interrupt_at > 0) begin
         repeat (interrupt_at) begin @(posedge clk); #1; end
         mode = MODE_FILL; src_addr = 32'd0; dst_addr = 32'd150; length = 16'd2;
         fill_value = 32'h1111_2222; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      budget = 200;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      if (budget == 0) begin
         checks++; failures++;
         $display("FAIL timeout: got %0d pending cycles expected 0", exp_q.size());
         exp_q.delete();
      end
      #1;
   endtask

   initial begin
      int w0, d0, b0, diffs;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_words_done", 32'(words_done), 32'd0);
      chk("reset_mem_write", 32'(mem_write), 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) mem_init(i, 32'h5A5A_0000 | 32'(i));

      // COPY 4 words
      for (int k = 0; k < 4; k++) mem_init(10 + k, 32'h1111_A000 + 32'(k));
      run_xfer(MODE_COPY, 10, 40, 4, 32'd0, 0);
      chk("copy_words_done", 32'(words_done), 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("copy_dst", tb_mem[40 + k], 32'h1111_A000 + 32'(k));
         chk("copy_src_kept", tb_mem[10 + k], 32'h1111_A000 + 32'(k));
      end

      // FILL 5 words
      w0 = wr_cnt;
      run_xfer(MODE_FILL, 0, 100, 5, 32'hDEAD_BEEF, 0);
      chk("fill_write_cycles", 32'(wr_cnt - w0), 32'd5);
      for (int k = 0; k < 5; k++) chk("fill_dst", tb_mem[100 + k], 32'hDEAD_BEEF);
      chk("fill_below", tb_mem[99], 32'h5A5A_0063);
      chk("fill_above", tb_mem[105], 32'h5A5A_0069);

      // Zero length
      w0 = wr_cnt; b0 = busy_cnt;
      run_xfer(MODE_COPY, 5, 7, 0, 32'd0, 0);
      chk("zero_writes", 32'(wr_cnt - w0), 32'd0);
      chk("zero_busy", 32'(busy_cnt - b0), 32'd0);
      chk("zero_words_done", 32'(words_done), 32'd0);

      // Overlapping forward copy
      for (int k = 0; k < 4; k++) mem_init(k, 32'(k + 1));
      run_xfer(MODE_COPY, 0, 1, 3, 32'd0, 0);
      for (int k = 0; k < 4; k++) chk("overlap", tb_mem[k], 32'd1);

      // Reset in the middle of an 8-word copy
      for (int k = 0; k < 8; k++) mem_init(20 + k, 32'hB000_0000 + 32'(k));
      cmp_en = 1'b0;
      w0 = wr_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      mode = MODE_COPY; src_addr = 32'd20; dst_addr = 32'd60; length = 16'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_words_done", 32'(words_done), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_writes", 32'(wr_cnt - w0), 32'd2);
      chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("rst_w0", tb_mem[60], 32'hB000_0000);
      chk("rst_w1", tb_mem[61], 32'hB000_0001);
      chk("rst_w2_untouched", tb_mem[62], 32'h5A5A_003E);
      model_mem[60] = 32'hB000_0000;
      model_mem[61] = 32'hB000_0001;
      model_wd = 16'd0;
      cmp_en = 1'b1;
      run_xfer(MODE_COPY, 20, 60, 8, 32'd0, 0);
      chk("rst_restart_last", tb_mem[67], 32'hB000_0007);

      // Stray start during WRITE, then during DONE
      d0 = done_cnt;
      run_xfer(MODE_COPY, 10, 200, 3, 32'd0, 1);
      chk("stray_one_done", 32'(done_cnt - d0), 32'd1);
      chk("stray_no_fill", tb_mem[150], 32'h5A5A_0096);
      run_xfer(MODE_FILL, 0, 120, 2, 32'hCAFE_0001, 2);
      chk("stray_fill_hi", tb_mem[121], 32'hCAFE_0001);
      chk("stray_fill_end", tb_mem[122], 32'h5A5A_007A);
      chk("stray_no_fill2", tb_mem[151], 32'h5A5A_0097);

      diffs = 0;
      for (int i = 0; i < 256; i++) if (tb_mem[i] !== model_mem[i]) diffs++;
      chk("memory_image_diffs", 32'(diffs), 32'd0);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
